// File: rtl/bitcount_engine_if.sv
// Start/finish handshake bundle for bitcount_engine.
// Optional parity output is present only when BITCOUNT_ENGINE_PARITY_EN is defined.
interface bitcount_engine_if #(
    parameter int WIDTH = 32
);
    localparam int OUT_W = $clog2(WIDTH + 1);

    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] in;
    logic             busy;
    logic             finish;
    logic [OUT_W-1:0] count;
    logic             ignored;
`ifdef BITCOUNT_ENGINE_PARITY_EN
    logic             parity;
`endif

    modport master (
        output start, mode, in,
        input  busy, finish, count, ignored
`ifdef BITCOUNT_ENGINE_PARITY_EN
        , input parity
`endif
    );

    modport slave (
        input  start, mode, in,
        output busy, finish, count, ignored
`ifdef BITCOUNT_ENGINE_PARITY_EN
        , output parity
`endif
    );
endinterface

// File: rtl/bitcount_engine.sv
// Multi-mode bit counter: ones / zeros / leading zeros / trailing zeros,
// scanning CHUNK bits per cycle, LSB-first (mode 2 bit-reverses the operand).
// Optional feature macro: BITCOUNT_ENGINE_PARITY_EN adds a parity output.
module bitcount_engine #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst,
    bitcount_engine_if.slave    bus
);
    localparam int OUT_W = $clog2(WIDTH + 1);
    localparam int N     = WIDTH / CHUNK;
    localparam int KW    = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic             start_q_reg;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [1:0]       mode_reg, mode_next;
    logic [OUT_W-1:0] acc_reg, acc_next;
    logic [OUT_W-1:0] count_reg, count_next;
    logic [KW-1:0]    k_reg, k_next;
    logic             finish_reg, finish_next;
    logic             ignored_reg, ignored_next;
`ifdef BITCOUNT_ENGINE_PARITY_EN
    logic             par_acc_reg, par_acc_next;
    logic             parity_reg, parity_next;
`endif

    logic             start_edge;
    logic [WIDTH-1:0] in_rev;
    logic [CHUNK-1:0] chunk;
    logic [OUT_W-1:0] pop;
    logic [OUT_W-1:0] low_idx;
    logic [OUT_W-1:0] add;
    logic [OUT_W-1:0] acc_sum;
    logic             hit;
    logic             job_done;

    assign start_edge = bus.start && !start_q_reg;

    // Leading-zero count becomes a trailing-zero count on the mirrored operand.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign in_rev[gi] = bus.in[WIDTH-1-gi];
        end
    endgenerate

    // Analyse the current chunk and work out this cycle's accumulator increment.
    always_comb begin
        chunk   = shift_reg[CHUNK-1:0];
        pop     = '0;
        low_idx = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            pop = pop + OUT_W'(chunk[i]);
            if (chunk[i]) begin
                low_idx = OUT_W'(i);
            end
        end
        hit = |chunk;
        case (mode_reg)
            2'd0:    add = pop;
            2'd1:    add = OUT_W'(CHUNK) - pop;
            default: add = hit ? low_idx : OUT_W'(CHUNK);
        endcase
        acc_sum  = acc_reg + add;
        // Zero-count modes stop at the first set bit; popcounts scan everything.
        job_done = (k_reg == KW'(N - 1)) || (mode_reg[1] && hit);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            start_q_reg <= 1'b0;
            shift_reg   <= '0;
            mode_reg    <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            k_reg       <= '0;
            finish_reg  <= 1'b0;
            ignored_reg <= 1'b0;
`ifdef BITCOUNT_ENGINE_PARITY_EN
            par_acc_reg <= 1'b0;
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            start_q_reg <= bus.start;
            shift_reg   <= shift_next;
            mode_reg    <= mode_next;
            acc_reg     <= acc_next;
            count_reg   <= count_next;
            k_reg       <= k_next;
            finish_reg  <= finish_next;
            ignored_reg <= ignored_next;
`ifdef BITCOUNT_ENGINE_PARITY_EN
            par_acc_reg <= par_acc_next;
            parity_reg  <= parity_next;
`endif
        end
    end

    // Next-state logic: accept in IDLE, one chunk per cycle in RUN.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        mode_next    = mode_reg;
        acc_next     = acc_reg;
        count_next   = count_reg;
        k_next       = k_reg;
        finish_next  = finish_reg;
        ignored_next = 1'b0;
`ifdef BITCOUNT_ENGINE_PARITY_EN
        par_acc_next = par_acc_reg;
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    shift_next  = (bus.mode == 2'd2) ? in_rev : bus.in;
                    mode_next   = bus.mode;
                    acc_next    = '0;
                    k_next      = '0;
                    finish_next = 1'b0;
                    state_next  = RUN;
`ifdef BITCOUNT_ENGINE_PARITY_EN
                    par_acc_next = 1'b0;
`endif
                end
            end
            RUN: begin
                // The completion cycle still counts as busy for a new edge.
                ignored_next = start_edge;
                if (job_done) begin
                    count_next  = acc_sum;
                    finish_next = 1'b1;
                    state_next  = IDLE;
`ifdef BITCOUNT_ENGINE_PARITY_EN
                    parity_next = mode_reg[1] ? 1'b0 : (par_acc_reg ^ (^chunk));
`endif
                end else begin
                    acc_next   = acc_sum;
                    shift_next = shift_reg >> CHUNK;
                    k_next     = k_reg + KW'(1);
`ifdef BITCOUNT_ENGINE_PARITY_EN
                    par_acc_next = par_acc_reg ^ (^chunk);
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs come straight from registered state.
    always_comb begin
        bus.busy    = (state_reg == RUN);
        bus.finish  = finish_reg;
        bus.count   = count_reg;
        bus.ignored = ignored_reg;
`ifdef BITCOUNT_ENGINE_PARITY_EN
        bus.parity  = parity_reg;
`endif
    end
endmodule

// File: tb/tb_bitcount_engine.sv
// Self-checking bench for bitcount_engine (WIDTH=32, CHUNK=4): directed jobs
// plus randomized start/mode/operand traffic against a job-level reference model.
module tb_bitcount_engine;
    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitcount_engine_if #(.WIDTH(WIDTH)) bus();
    bitcount_engine #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Result of a job, straight from the definition of each mode.
    function automatic int ref_count(input logic [1:0] m, input logic [31:0] d);
        int ones, lz, tz;
        ones = $countones(d);
        lz = 0;
        while (lz < WIDTH && d[WIDTH-1-lz] == 1'b0) lz++;
        tz = 0;
        while (tz < WIDTH && d[tz] == 1'b0) tz++;
        case (m)
            2'd0:    return ones;
            2'd1:    return WIDTH - ones;
            2'd2:    return lz;
            default: return tz;
        endcase
    endfunction

    // Cycles from the accepted edge until finish is visible.
    function automatic int ref_latency(input logic [1:0] m, input logic [31:0] d);
        if (m < 2'd2 || d == 0) return N + 1;
        return ref_count(m, d) / CHUNK + 2;
    endfunction

    // Reference model: job-level view of the handshake, updated each rising edge.
    logic        exp_busy, exp_finish, exp_ignored, exp_parity;
    logic [31:0] exp_count;
    initial begin
        bit   prev_start, edge_seen, job_parity;
        int   busy_left, job_result;
        prev_start = 0; busy_left = 0; job_result = 0; job_parity = 0;
        exp_busy = 0; exp_finish = 0; exp_ignored = 0; exp_parity = 0; exp_count = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                prev_start = 0; busy_left = 0;
                exp_busy = 0; exp_finish = 0; exp_ignored = 0; exp_parity = 0; exp_count = 0;
            end else begin
                edge_seen   = bus.start && !prev_start;
                prev_start  = bus.start;
                exp_ignored = 0;
                if (busy_left > 0) begin
                    if (edge_seen) exp_ignored = 1;
                    busy_left--;
                    if (busy_left == 0) begin
                        exp_busy   = 0;
                        exp_finish = 1;
                        exp_count  = job_result;
                        exp_parity = job_parity;
                    end
                end else if (edge_seen) begin
                    job_result = ref_count(bus.mode, bus.in);
                    job_parity = (bus.mode < 2'd2) ? ^bus.in : 1'b0;
                    busy_left  = ref_latency(bus.mode, bus.in) - 1;
                    exp_busy   = 1;
                    exp_finish = 0;
                end
            end
        end
    end

    // Compare process: every cycle, outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("busy", bus.busy, exp_busy);
                check("finish", bus.finish, exp_finish);
                check("count", bus.count, exp_count);
                check("ignored", bus.ignored, exp_ignored);
`ifdef BITCOUNT_ENGINE_PARITY_EN
                check("parity", bus.parity, exp_parity);
`endif
            end
        end
    end

    // One job: start held for 'hold' cycles, optional second edge at cycle 'reedge'.
    task automatic job(input logic [1:0] m, input logic [31:0] d, input int hold,
                       input int reedge, output int lat, output logic [31:0] cnt,
                       output int ign_n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.in    = d;
        lat = -1; cnt = '0; ign_n = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) check("busy_after_edge", bus.busy, 1);
            if (bus.ignored && ign_n < 0) ign_n = n;
            if (lat < 0 && bus.finish) begin
                lat = n;
                cnt = bus.count;
            end
            bus.start = (n < hold) || (reedge > 0 && n == reedge);
            bus.mode  = 2'($urandom);
            bus.in    = $urandom;
            if (lat >= 0 && n >= hold + 1 && n >= lat + 2) break;
        end
        if (lat < 0) check("job_timeout", 0, 1);
        $display("job mode=%0d in=%h latency=%0d count=%0d", m, d, lat, cnt);
    endtask

    initial begin
        int          lat, ign_n, seen;
        logic [31:0] cnt;
        bus.start = 0; bus.mode = 0; bus.in = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_finish", bus.finish, 0);
        check("rst_count", bus.count, 0);
        check("rst_ignored", bus.ignored, 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Pin the model with hand-computed values.
        check("model_ones", ref_count(2'd0, 32'hF0F0_0001), 9);
        check("model_zeros", ref_count(2'd1, 32'h0000_0000), 32);
        check("model_lz", ref_count(2'd2, 32'h0001_0000), 15);
        check("model_tz", ref_count(2'd3, 32'h0000_0100), 8);
        check("model_lat_tz", ref_latency(2'd3, 32'h0000_0100), 4);

        job(2'd0, 32'hF0F0_0001, 1, 0, lat, cnt, ign_n);
        check("ones_lat", lat, 9);  check("ones_cnt", cnt, 9);
        job(2'd1, 32'hFFFF_FFFF, 1, 0, lat, cnt, ign_n);
        check("zeros_lat", lat, 9); check("zeros_cnt", cnt, 0);
        job(2'd1, 32'h0000_0000, 1, 0, lat, cnt, ign_n);
        check("zeros0_lat", lat, 9); check("zeros0_cnt", cnt, 32);
        job(2'd3, 32'h0000_0100, 1, 0, lat, cnt, ign_n);
        check("tz_lat", lat, 4);    check("tz_cnt", cnt, 8);
        job(2'd2, 32'h0001_0000, 1, 0, lat, cnt, ign_n);
        check("lz_lat", lat, 5);    check("lz_cnt", cnt, 15);
        job(2'd2, 32'h0000_0000, 1, 3, lat, cnt, ign_n);
        check("lz0_lat", lat, 9);   check("lz0_cnt", cnt, 32);
        check("ignored_cycle", ign_n, 4);
        job(2'd0, 32'h0000_0003, 20, 0, lat, cnt, ign_n);
        check("hold_lat", lat, 9);  check("hold_cnt", cnt, 2);
        check("hold_busy_after", bus.busy, 0);
        job(2'd0, 32'h0000_0007, 1, 0, lat, cnt, ign_n);
        check("par_cnt", cnt, 3);
`ifdef BITCOUNT_ENGINE_PARITY_EN
        check("par_val", bus.parity, 1);
`endif

        // Reset in the middle of a job.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'd0; bus.in = 32'h3;
        seen = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (n == 4) rst = 1'b1;
            if (n == 5) begin
                check("midrst_busy", bus.busy, 0);
                check("midrst_finish", bus.finish, 0);
                check("midrst_count", bus.count, 0);
                rst = 1'b0;
            end
            if (n > 5 && bus.finish) seen = 1;
        end
        check("midrst_no_finish", seen, 0);
        $display("job mode=0 in=00000003 aborted by reset");

        // Randomized traffic: start toggles, operand patterns, rare resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.start = ~bus.start;
            bus.mode = 2'($urandom);
            case ($urandom_range(0, 4))
                0: bus.in = $urandom;
                1: bus.in = 32'h1 << $urandom_range(0, 31);
                2: bus.in = 32'h0;
                3: bus.in = 32'hFFFF_FFFF;
                default: bus.in = $urandom & $urandom & $urandom;
            endcase
            rst = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
